cpu_run_ctrl: RTL and testbench



---
 rtl/cpu_run_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control block that sits between the board clock/reset and the core.
// It provides a stretched core reset, a divided free-run enable, single-step, halt/resume,
// and a saturating count of enabled cycles.
// Optional watchdog: define RUN_CTRL_WATCHDOG_EN. With it undefined, heartbeat is ignored
// and wdog_trip is tied to 0.
module cpu_run_ctrl #(
    parameter int RST_CYCLES  = 5,
    parameter int DIV         = 1,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             mode_step,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             heartbeat,
    output logic             core_rst,
    output logic             core_en,
    output logic             step_done,
    output logic             halted,
    output logic             wdog_trip,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_STEP_IDLE,
        S_STEP_FIRE,
        S_HALTED
    } state_t;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [DIV_W-1:0]    r_div;
    logic                r_halt_pend;
    logic                r_step_s;
    logic                r_step_prev;
    logic                r_core_rst;
    logic                r_core_en;
    logic                r_step_done;
    logic                r_halted;
    logic [CNT_W-1:0]    r_cycle_cnt;

    logic                w_step_rise;
    logic                w_div_last;
    logic [DIV_W-1:0]    w_div_next;
    logic                w_div_next_last;
    logic                w_hold_done;
    logic                w_wdog_hit;
    logic                w_resume_go;

    // step_req is registered once, then compared with its previous sample, so a step
    // is recognised one edge after it is first sampled high
    assign w_step_rise     = r_step_s & ~r_step_prev;
    assign w_div_last      = (r_div == DIV_W'(DIV - 1));
    assign w_div_next      = w_div_last ? '0 : r_div + 1'b1;
    assign w_div_next_last = (w_div_next == DIV_W'(DIV - 1));
    assign w_hold_done     = (r_hold_cnt == HOLD_W'(RST_CYCLES - 1));
    assign w_resume_go     = (r_state == S_HALTED) && resume && !halt_req;

    // Main run-control FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_div       <= '0;
            r_halt_pend <= 1'b0;
            r_step_s    <= 1'b1;
            r_step_prev <= 1'b1;
            r_core_rst  <= 1'b1;
            r_core_en   <= 1'b0;
            r_step_done <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_step_s    <= step_req;
            r_step_prev <= r_step_s;
            r_core_rst  <= 1'b0;
            r_core_en   <= 1'b0;
            r_step_done <= 1'b0;
            r_halted    <= 1'b0;
            if (w_wdog_hit) begin
                r_state  <= S_HALTED;
                r_halted <= 1'b1;
                r_div    <= '0;
            end else begin
                case (r_state)
                    S_HOLD: begin
                        r_core_rst  <= 1'b1;
                        r_halt_pend <= r_halt_pend | halt_req;
                        if (w_hold_done) begin
                            r_core_rst <= 1'b0;
                            if (r_halt_pend || halt_req) begin
                                r_state  <= S_HALTED;
                                r_halted <= 1'b1;
                            end else if (mode_step) begin
                                r_state <= S_STEP_IDLE;
                            end else begin
                                r_state   <= S_RUN;
                                r_div     <= '0;
                                r_core_en <= (DIV == 1);
                            end
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (halt_req) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                            r_div    <= '0;
                        end else if (mode_step) begin
                            r_state <= S_STEP_IDLE;
                            r_div   <= '0;
                        end else begin
                            r_div     <= w_div_next;
                            r_core_en <= w_div_next_last;
                        end
                    end
                    S_STEP_IDLE: begin
                        if (halt_req) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                        end else if (!mode_step) begin
                            r_state   <= S_RUN;
                            r_div     <= '0;
                            r_core_en <= (DIV == 1);
                        end else if (w_step_rise) begin
                            r_state     <= S_STEP_FIRE;
                            r_core_en   <= 1'b1;
                            r_step_done <= 1'b1;
                        end
                    end
                    S_STEP_FIRE: begin
                        r_state <= S_STEP_IDLE;
                    end
                    S_HALTED: begin
                        if (w_resume_go) begin
                            if (mode_step) begin
                                r_state <= S_STEP_IDLE;
                            end else begin
                                r_state   <= S_RUN;
                                r_div     <= '0;
                                r_core_en <= (DIV == 1);
                            end
                        end else begin
                            r_halted <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_HOLD;
                    end
                endcase
            end
        end
    end

    // Enabled-cycle counter, stops at all-ones instead of wrapping
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cycle_cnt <= '0;
        end else if (r_core_en && (r_cycle_cnt != {CNT_W{1'b1}})) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] r_wdog_cnt;
    logic            r_wdog_trip;

    // Trip on the edge that closes the WDOG_CYCLES-th enabled cycle without progress
    assign w_wdog_hit = r_core_en && !heartbeat && (r_wdog_cnt == WD_W'(WDOG_CYCLES - 1));

    // Progress watchdog: counts enabled cycles, cleared by heartbeat or resume; trip is sticky
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b0;
        end else if (w_wdog_hit) begin
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b1;
        end else if (heartbeat || w_resume_go) begin
            r_wdog_cnt <= '0;
        end else if (r_core_en) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    assign wdog_trip = r_wdog_trip;
`else
    logic w_unused;

    assign w_wdog_hit = 1'b0;
    assign wdog_trip  = 1'b0;
    assign w_unused   = heartbeat;
`endif

    assign core_rst  = r_core_rst;
    assign core_en   = r_core_en;
    assign step_done = r_step_done;
    assign halted    = r_halted;
    assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two instances (DIV=1/CNT_W=4 and DIV=3/CNT_W=8) share stimulus.
// The stimulus process queues expected per-cycle outputs, and a negedge monitor checks them.
module tb_cpu_run_ctrl;

    localparam int SIG_RST  = 0;
    localparam int SIG_EN   = 1;
    localparam int SIG_SD   = 2;
    localparam int SIG_HALT = 3;
    localparam int SIG_TRIP = 4;
    localparam int SIG_CNT  = 5;

    logic CLK = 1'b0;
    logic RST, mode_step, step_req, halt_req, resume, heartbeat;

    logic       a_rst, a_en, a_sd, a_halt, a_trip;
    logic [3:0] a_cnt;
    logic       b_rst, b_en, b_sd, b_halt, b_trip;
    logic [7:0] b_cnt;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int    cyc;
        int    inst;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];

    cpu_run_ctrl #(.RST_CYCLES(5), .DIV(1), .CNT_W(4), .WDOG_CYCLES(8)) u_a (
        .CLK(CLK), .RST(RST), .mode_step(mode_step), .step_req(step_req),
        .halt_req(halt_req), .resume(resume), .heartbeat(heartbeat),
        .core_rst(a_rst), .core_en(a_en), .step_done(a_sd), .halted(a_halt),
        .wdog_trip(a_trip), .cycle_cnt(a_cnt)
    );

    cpu_run_ctrl #(.RST_CYCLES(5), .DIV(3), .CNT_W(8), .WDOG_CYCLES(1000)) u_b (
        .CLK(CLK), .RST(RST), .mode_step(mode_step), .step_req(step_req),
        .halt_req(halt_req), .resume(resume), .heartbeat(heartbeat),
        .core_rst(b_rst), .core_en(b_en), .step_done(b_sd), .halted(b_halt),
        .wdog_trip(b_trip), .cycle_cnt(b_cnt)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int get_out(input int inst, input int sig);
        logic [7:0] v;
        v = 8'd0;
        if (inst == 0) begin
            case (sig)
                SIG_RST:  v = {7'd0, a_rst};
                SIG_EN:   v = {7'd0, a_en};
                SIG_SD:   v = {7'd0, a_sd};
                SIG_HALT: v = {7'd0, a_halt};
                SIG_TRIP: v = {7'd0, a_trip};
                default:  v = {4'd0, a_cnt};
            endcase
        end else begin
            case (sig)
                SIG_RST:  v = {7'd0, b_rst};
                SIG_EN:   v = {7'd0, b_en};
                SIG_SD:   v = {7'd0, b_sd};
                SIG_HALT: v = {7'd0, b_halt};
                SIG_TRIP: v = {7'd0, b_trip};
                default:  v = b_cnt;
            endcase
        end
        return int'(v);
    endfunction

    // Monitor: each cycle, pop every expectation tagged for this cycle and compare
    always @(negedge CLK) begin
        exp_t e;
        int   act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = get_out(e.inst, e.sig);
            n_tests++;
            if (e.cyc != cyc || act != e.val) begin
                n_fail++;
                $display("FAIL %s inst=%0d sig=%0d cyc=%0d actual=%0d required=%0d",
                         e.name, e.inst, e.sig, e.cyc, act, e.val);
            end else begin
                $display("ok   %s inst=%0d sig=%0d cyc=%0d value=%0d",
                         e.name, e.inst, e.sig, cyc, act);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_v(input string name, input int inst, input int sig, input int val);
        sb.push_back('{cyc, inst, sig, val, name});
    endtask

    task automatic chk_reset(input string name);
        for (int k = 0; k < 2; k++) begin
            expect_v(name, k, SIG_RST, 1);
            expect_v(name, k, SIG_EN, 0);
            expect_v(name, k, SIG_SD, 0);
            expect_v(name, k, SIG_HALT, 0);
            expect_v(name, k, SIG_TRIP, 0);
            expect_v(name, k, SIG_CNT, 0);
        end
    endtask

    // Stretch check over the five HOLD edges after RST drops; A_en_last is A's core_en after the fifth
    task automatic hold_phase(input string name, input int a_en_last);
        for (int i = 1; i <= 5; i++) begin
            tick();
            expect_v(name, 0, SIG_RST, (i < 5) ? 1 : 0);
            expect_v(name, 1, SIG_RST, (i < 5) ? 1 : 0);
            expect_v(name, 0, SIG_EN, (i == 5) ? a_en_last : 0);
            expect_v(name, 1, SIG_EN, 0);
        end
    endtask

    // Step stimulus: step_req before each edge, and the step_done expected after it
    bit sv_tab [20] = '{1,1,1,1,0,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0,0};
    bit sd_tab [20] = '{0,1,0,0,0,0,0, 0,1,0,0, 0,1,0,0, 0,1,0,0,0};

    initial begin
        int run;
        RST = 1'b1; mode_step = 1'b0; step_req = 1'b0;
        halt_req = 1'b0; resume = 1'b0; heartbeat = 1'b1;
        #1;
        repeat (3) begin
            tick();
            chk_reset("reset_state");
        end

        // Reset stretch, then free-run on both dividers, with A saturating at 15
        RST = 1'b0;
        hold_phase("rst_stretch", 1);
        for (int j = 1; j <= 30; j++) begin
            tick();
            expect_v("run_en", 0, SIG_EN, 1);
            expect_v("run_cnt", 0, SIG_CNT, (j < 15) ? j : 15);
            expect_v("div3_en", 1, SIG_EN, (j % 3 == 2) ? 1 : 0);
            expect_v("div3_cnt", 1, SIG_CNT, j / 3);
        end

        // halt_req and resume together: halt wins
        halt_req = 1'b1; resume = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            expect_v("halt_sim", k, SIG_HALT, 1);
            expect_v("halt_sim", k, SIG_EN, 0);
        end
        expect_v("sat_hold", 0, SIG_CNT, 15);
        expect_v("div3_cnt30", 1, SIG_CNT, 10);
        tick();
        expect_v("halt_stay", 0, SIG_HALT, 1);
        expect_v("halt_stay", 1, SIG_HALT, 1);
        halt_req = 1'b0;
        tick();
        expect_v("resume", 0, SIG_HALT, 0);
        expect_v("resume", 1, SIG_HALT, 0);
        expect_v("resume_en", 0, SIG_EN, 1);
        expect_v("resume_div0", 1, SIG_EN, 0);
        resume = 1'b0;
        tick();
        expect_v("resume_div1", 1, SIG_EN, 0);
        tick();
        expect_v("resume_div2", 1, SIG_EN, 1);
        expect_v("resume_cnt", 1, SIG_CNT, 10);

        // Reset mid-run, then come out of HOLD straight into step mode
        RST = 1'b1; mode_step = 1'b1;
        tick();
        chk_reset("mid_reset");
        RST = 1'b0;
        hold_phase("step_hold", 0);
        run = 0;
        for (int n = 0; n < 20; n++) begin
            step_req = sv_tab[n];
            tick();
            for (int k = 0; k < 2; k++) begin
                expect_v("step_done", k, SIG_SD, int'(sd_tab[n]));
                expect_v("step_en", k, SIG_EN, int'(sd_tab[n]));
                expect_v("step_cnt", k, SIG_CNT, run);
            end
            if (sd_tab[n]) run++;
        end
        tick();
        expect_v("step_total", 0, SIG_CNT, 4);
        expect_v("step_total", 1, SIG_CNT, 4);

        // halt_req seen during HOLD lands in HALTED; resume goes to STEP_IDLE; mode change to RUN
        RST = 1'b1;
        tick();
        chk_reset("pend_reset");
        RST = 1'b0; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        repeat (4) tick();
        expect_v("pend_halt", 0, SIG_HALT, 1);
        expect_v("pend_halt", 1, SIG_HALT, 1);
        expect_v("pend_rst", 0, SIG_RST, 0);
        resume = 1'b1;
        tick();
        expect_v("pend_resume", 0, SIG_HALT, 0);
        expect_v("pend_resume_en", 0, SIG_EN, 0);
        resume = 1'b0; mode_step = 1'b0;
        tick();
        expect_v("idle_to_run", 0, SIG_EN, 1);
        expect_v("idle_to_run", 1, SIG_EN, 0);

`ifdef RUN_CTRL_WATCHDOG_EN
        // No heartbeat: A trips after 8 enabled cycles
        RST = 1'b1; heartbeat = 1'b0;
        tick();
        chk_reset("wd_reset");
        RST = 1'b0;
        hold_phase("wd_hold", 1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            expect_v("wd_halt", 0, SIG_HALT, (j == 8) ? 1 : 0);
            expect_v("wd_trip", 0, SIG_TRIP, (j == 8) ? 1 : 0);
            expect_v("wd_en", 0, SIG_EN, (j == 8) ? 0 : 1);
        end
        expect_v("wd_cnt", 0, SIG_CNT, 8);
        resume = 1'b1;
        tick();
        expect_v("wd_resume", 0, SIG_HALT, 0);
        expect_v("wd_sticky", 0, SIG_TRIP, 1);
        expect_v("wd_resume_en", 0, SIG_EN, 1);
        resume = 1'b0;
        // Heartbeat every 5 cycles keeps it from tripping
        RST = 1'b1;
        tick();
        chk_reset("wd_reset2");
        RST = 1'b0;
        hold_phase("wd_hold2", 1);
        for (int j = 1; j <= 30; j++) begin
            heartbeat = (j % 5 == 0);
            tick();
            expect_v("wd_hb_halt", 0, SIG_HALT, 0);
            expect_v("wd_hb_trip", 0, SIG_TRIP, 0);
            expect_v("wd_hb_en", 0, SIG_EN, 1);
        end
`else
        // Without the watchdog, a long run with no heartbeat never halts
        RST = 1'b1; heartbeat = 1'b0;
        tick();
        chk_reset("nowd_reset");
        RST = 1'b0;
        hold_phase("nowd_hold", 1);
        for (int j = 1; j <= 12; j++) begin
            tick();
            expect_v("nowd_halt", 0, SIG_HALT, 0);
            expect_v("nowd_trip", 0, SIG_TRIP, 0);
            expect_v("nowd_en", 0, SIG_EN, 1);
        end
`endif

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge CLK);
        #1;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
